issuequeue_int: RTL and testbench



---
 rtl/issuequeue_int.sv | 227 ++++++++++++++++++++++
 tb/tb_issuequeue_int.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/issuequeue_int.sv
// issuequeue_int -- integer-class issue queue.
//
// Holds dispatched integer/branch ops in a collapsing, age-ordered array
// (entry 0 is oldest, valid entries contiguous from 0). Pending source
// operands snoop the CDB and capture the broadcast value on a tag match.
// The oldest entry with both operands ready is presented to the issue unit
// and is removed when the issue unit grants it.
//
// Optional feature macro: ISSUEQ_WAKEUP_BYPASS_EN
//   defined   -> a same-cycle CDB match counts as ready for select, and the
//                payload forwards cdb_out for that operand.
//   undefined -> select uses registered ready bits only (1-cycle wakeup).
//
// Ports:
//   clk, reset                  clock / synchronous active-high reset
//   dispatch_*                  new entry from dispatch/rename
//   issuequeue_full             all DEPTH entries occupied (registered)
//   issuequeue_count            occupied entries
//   cdb_valid/cdb_tagout/cdb_out  CDB broadcast
//   ready_int                   an entry with both operands ready is presented
//   issue_int                   grant; consumes the presented entry
//   opcode/rsdata/rtdata/rdtag  presented payload (0 while ready_int=0)
module issuequeue_int #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 6,
  parameter int DATAW = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dispatch_en,
  input  logic [3:0]                   dispatch_opcode,
  input  logic [DATAW-1:0]             dispatch_rsdata,
  input  logic [TAGW-1:0]              dispatch_rstag,
  input  logic                         dispatch_rsvalid,
  input  logic [DATAW-1:0]             dispatch_rtdata,
  input  logic [TAGW-1:0]              dispatch_rttag,
  input  logic                         dispatch_rtvalid,
  input  logic [TAGW-1:0]              dispatch_rdtag,
  output logic                         issuequeue_full,
  input  logic                         cdb_valid,
  input  logic [TAGW-1:0]              cdb_tagout,
  input  logic [DATAW-1:0]             cdb_out,
  output logic                         ready_int,
  input  logic                         issue_int,
  output logic [3:0]                   opcode,
  output logic [DATAW-1:0]             rsdata,
  output logic [DATAW-1:0]             rtdata,
  output logic [TAGW-1:0]              rdtag,
  output logic [$clog2(DEPTH+1)-1:0]   issuequeue_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  // Registered entry state
  logic [DEPTH-1:0] vld, rs_rdy, rt_rdy;
  logic [3:0]       op_q   [DEPTH];
  logic [TAGW-1:0]  rd_q   [DEPTH];
  logic [TAGW-1:0]  rs_tag [DEPTH];
  logic [TAGW-1:0]  rt_tag [DEPTH];
  logic [DATAW-1:0] rs_dat [DEPTH];
  logic [DATAW-1:0] rt_dat [DEPTH];
  logic [CW-1:0]    count;
  logic             full;

  // Entry state after this cycle's wakeup; one extra all-zero slot so the
  // collapse shift of the top entry reads an empty entry.
  logic             w_vld    [DEPTH+1];
  logic             w_rs_rdy [DEPTH+1];
  logic             w_rt_rdy [DEPTH+1];
  logic [3:0]       w_op     [DEPTH+1];
  logic [TAGW-1:0]  w_rd     [DEPTH+1];
  logic [TAGW-1:0]  w_rs_tag [DEPTH+1];
  logic [TAGW-1:0]  w_rt_tag [DEPTH+1];
  logic [DATAW-1:0] w_rs_dat [DEPTH+1];
  logic [DATAW-1:0] w_rt_dat [DEPTH+1];

  logic [DEPTH-1:0] rs_hit, rt_hit, eff_rs, eff_rt;
  logic [IW-1:0]    sel;
  logic             found, grant, accept;
  logic [CW-1:0]    wr_idx, count_nxt;
  logic             d_rs_hit, d_rt_hit;

  logic             n_vld    [DEPTH];
  logic             n_rs_rdy [DEPTH];
  logic             n_rt_rdy [DEPTH];
  logic [3:0]       n_op     [DEPTH];
  logic [TAGW-1:0]  n_rd     [DEPTH];
  logic [TAGW-1:0]  n_rs_tag [DEPTH];
  logic [TAGW-1:0]  n_rt_tag [DEPTH];
  logic [DATAW-1:0] n_rs_dat [DEPTH];
  logic [DATAW-1:0] n_rt_dat [DEPTH];

  // CDB snoop and wakeup
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rs_hit[i] = vld[i] & ~rs_rdy[i] & cdb_valid & (rs_tag[i] == cdb_tagout);
      rt_hit[i] = vld[i] & ~rt_rdy[i] & cdb_valid & (rt_tag[i] == cdb_tagout);
`ifdef ISSUEQ_WAKEUP_BYPASS_EN
      eff_rs[i] = rs_rdy[i] | rs_hit[i];
      eff_rt[i] = rt_rdy[i] | rt_hit[i];
`else
      eff_rs[i] = rs_rdy[i];
      eff_rt[i] = rt_rdy[i];
`endif
      w_vld[i]    = vld[i];
      w_rs_rdy[i] = rs_rdy[i] | rs_hit[i];
      w_rt_rdy[i] = rt_rdy[i] | rt_hit[i];
      w_op[i]     = op_q[i];
      w_rd[i]     = rd_q[i];
      w_rs_tag[i] = rs_tag[i];
      w_rt_tag[i] = rt_tag[i];
      w_rs_dat[i] = rs_hit[i] ? cdb_out : rs_dat[i];
      w_rt_dat[i] = rt_hit[i] ? cdb_out : rt_dat[i];
    end
    w_vld[DEPTH]    = 1'b0;
    w_rs_rdy[DEPTH] = 1'b0;
    w_rt_rdy[DEPTH] = 1'b0;
    w_op[DEPTH]     = '0;
    w_rd[DEPTH]     = '0;
    w_rs_tag[DEPTH] = '0;
    w_rt_tag[DEPTH] = '0;
    w_rs_dat[DEPTH] = '0;
    w_rt_dat[DEPTH] = '0;
  end

  // Select: lowest-index (oldest) valid entry with both operands ready
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld[i] && eff_rs[i] && eff_rt[i]) begin
        sel   = IW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ready_int = found;
    opcode    = '0;
    rsdata    = '0;
    rtdata    = '0;
    rdtag     = '0;
    if (found) begin
      opcode = op_q[sel];
      rdtag  = rd_q[sel];
`ifdef ISSUEQ_WAKEUP_BYPASS_EN
      rsdata = rs_hit[sel] ? cdb_out : rs_dat[sel];
      rtdata = rt_hit[sel] ? cdb_out : rt_dat[sel];
`else
      rsdata = rs_dat[sel];
      rtdata = rt_dat[sel];
`endif
    end
  end

  assign grant     = issue_int & found;
  assign accept    = dispatch_en & ~full;
  // A same-cycle grant collapses one entry, so the write slot moves down.
  assign wr_idx    = count - CW'(grant);
  assign count_nxt = count + CW'(accept) - CW'(grant);
  assign d_rs_hit  = ~dispatch_rsvalid & cdb_valid & (dispatch_rstag == cdb_tagout);
  assign d_rt_hit  = ~dispatch_rtvalid & cdb_valid & (dispatch_rttag == cdb_tagout);

  // Collapse on grant, then insert the dispatched entry
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [CW-1:0] src;
      src = (grant && (i >= int'(sel))) ? CW'(i + 1) : CW'(i);
      n_vld[i]    = w_vld[src];
      n_rs_rdy[i] = w_rs_rdy[src];
      n_rt_rdy[i] = w_rt_rdy[src];
      n_op[i]     = w_op[src];
      n_rd[i]     = w_rd[src];
      n_rs_tag[i] = w_rs_tag[src];
      n_rt_tag[i] = w_rt_tag[src];
      n_rs_dat[i] = w_rs_dat[src];
      n_rt_dat[i] = w_rt_dat[src];
      if (accept && (CW'(i) == wr_idx)) begin
        n_vld[i]    = 1'b1;
        n_rs_rdy[i] = dispatch_rsvalid | d_rs_hit;
        n_rt_rdy[i] = dispatch_rtvalid | d_rt_hit;
        n_op[i]     = dispatch_opcode;
        n_rd[i]     = dispatch_rdtag;
        n_rs_tag[i] = dispatch_rstag;
        n_rt_tag[i] = dispatch_rttag;
        n_rs_dat[i] = d_rs_hit ? cdb_out : dispatch_rsdata;
        n_rt_dat[i] = d_rt_hit ? cdb_out : dispatch_rtdata;
      end
    end
  end

  // State update: control with reset, payload without
  always_ff @(posedge clk) begin
    if (reset) begin
      vld    <= '0;
      rs_rdy <= '0;
      rt_rdy <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vld[i]    <= n_vld[i];
        rs_rdy[i] <= n_rs_rdy[i];
        rt_rdy[i] <= n_rt_rdy[i];
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      op_q[i]   <= n_op[i];
      rd_q[i]   <= n_rd[i];
      rs_tag[i] <= n_rs_tag[i];
      rt_tag[i] <= n_rt_tag[i];
      rs_dat[i] <= n_rs_dat[i];
      rt_dat[i] <= n_rt_dat[i];
    end
  end

  assign issuequeue_full  = full;
  assign issuequeue_count = count;

endmodule

// File: tb/tb_issuequeue_int.sv
module tb_issuequeue_int;

  logic        clk = 1'b0;
  logic        reset;
  logic        dispatch_en;
  logic [3:0]  dispatch_opcode;
  logic [31:0] dispatch_rsdata, dispatch_rtdata;
  logic [5:0]  dispatch_rstag, dispatch_rttag, dispatch_rdtag;
  logic        dispatch_rsvalid, dispatch_rtvalid;
  logic        issuequeue_full;
  logic        cdb_valid;
  logic [5:0]  cdb_tagout;
  logic [31:0] cdb_out;
  logic        ready_int, issue_int;
  logic [3:0]  opcode;
  logic [31:0] rsdata, rtdata;
  logic [5:0]  rdtag;
  logic [2:0]  issuequeue_count;

  issuequeue_int #(.DEPTH(4), .TAGW(6), .DATAW(32)) dut (
    .clk(clk), .reset(reset),
    .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
    .dispatch_rsdata(dispatch_rsdata), .dispatch_rstag(dispatch_rstag),
    .dispatch_rsvalid(dispatch_rsvalid),
    .dispatch_rtdata(dispatch_rtdata), .dispatch_rttag(dispatch_rttag),
    .dispatch_rtvalid(dispatch_rtvalid),
    .dispatch_rdtag(dispatch_rdtag), .issuequeue_full(issuequeue_full),
    .cdb_valid(cdb_valid), .cdb_tagout(cdb_tagout), .cdb_out(cdb_out),
    .ready_int(ready_int), .issue_int(issue_int),
    .opcode(opcode), .rsdata(rsdata), .rtdata(rtdata), .rdtag(rdtag),
    .issuequeue_count(issuequeue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, den;
    logic [3:0]  dop;
    logic [31:0] drs;  logic [5:0] drstag; logic drsv;
    logic [31:0] drt;  logic [5:0] drttag; logic drtv;
    logic [5:0]  drd;
    logic        cv;   logic [5:0] ct;     logic [31:0] cd;
    logic        iss;
    logic        erdy; logic [3:0] eop;
    logic [31:0] ers, ert; logic [5:0] erd;
    logic [2:0]  ecnt; logic efull;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t v [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // control row: rst den iss, dispatch fields, cdb fields, then expected outputs
  function automatic vec_t mk(
      input logic rst, input logic den, input logic [3:0] dop,
      input logic [31:0] drs, input logic [5:0] drstag, input logic drsv,
      input logic [31:0] drt, input logic [5:0] drttag, input logic drtv,
      input logic [5:0] drd,
      input logic cv, input logic [5:0] ct, input logic [31:0] cd,
      input logic iss,
      input logic erdy, input logic [3:0] eop, input logic [31:0] ers,
      input logic [31:0] ert, input logic [5:0] erd,
      input logic [2:0] ecnt, input logic efull);
    vec_t r;
    r.rst = rst; r.den = den; r.dop = dop;
    r.drs = drs; r.drstag = drstag; r.drsv = drsv;
    r.drt = drt; r.drttag = drttag; r.drtv = drtv; r.drd = drd;
    r.cv = cv; r.ct = ct; r.cd = cd; r.iss = iss;
    r.erdy = erdy; r.eop = eop; r.ers = ers; r.ert = ert; r.erd = erd;
    r.ecnt = ecnt; r.efull = efull;
    return r;
  endfunction

  task automatic idle_inputs();
    reset = 0; dispatch_en = 0; dispatch_opcode = 0;
    dispatch_rsdata = 0; dispatch_rstag = 0; dispatch_rsvalid = 0;
    dispatch_rtdata = 0; dispatch_rttag = 0; dispatch_rtvalid = 0;
    dispatch_rdtag = 0; cdb_valid = 0; cdb_tagout = 0; cdb_out = 0;
    issue_int = 0;
  endtask

  task automatic check_outputs(input string tag, input vec_t r);
    check({tag, ".ready_int"}, {31'd0, ready_int}, {31'd0, r.erdy});
    check({tag, ".opcode"}, {28'd0, opcode}, {28'd0, r.eop});
    check({tag, ".rsdata"}, rsdata, r.ers);
    check({tag, ".rtdata"}, rtdata, r.ert);
    check({tag, ".rdtag"}, {26'd0, rdtag}, {26'd0, r.erd});
    check({tag, ".count"}, {29'd0, issuequeue_count}, {29'd0, r.ecnt});
    check({tag, ".full"}, {31'd0, issuequeue_full}, {31'd0, r.efull});
  endtask

  initial begin
    idle_inputs();
    //       rst den op  rs        rstag v  rt     rttag v  rd    cv ct   cd            iss | rdy op rs            rt       rd   cnt full
    v.push_back(mk(1,0,0, 0,0,0, 0,0,0, 0,  0,0,0, 0,  0,0,0,0,0, 0,0));                          // 0 reset
    v.push_back(mk(0,1,2, 5,0,1, 7,0,1, 9,  0,0,0, 0,  1,2,5,7,9, 1,0));                          // 1 ready dispatch
    v.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,  0,0,0, 1,  0,0,0,0,0, 0,0));                          // 2 grant
    v.push_back(mk(0,1,3, 0,12,0, 1,0,1, 10, 0,0,0, 0, 0,0,0,0,0, 1,0));                          // 3 rs pending tag 12
    v.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,  1,13,32'hFFFF, 1, 0,0,0,0,0, 1,0));                   // 4 stray tag, grant ignored
    v.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,  1,12,32'hDEADBEEF, 0, 1,3,32'hDEADBEEF,1,10, 1,0));   // 5 wakeup
    v.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,  0,0,0, 1,  0,0,0,0,0, 0,0));                          // 6 grant
    v.push_back(mk(0,1,1, 0,1,0, 32'h10,0,1, 1, 0,0,0, 0, 0,0,0,0,0, 1,0));                       // 7 fill e0
    v.push_back(mk(0,1,2, 0,2,0, 32'h20,0,1, 2, 0,0,0, 0, 0,0,0,0,0, 2,0));                       // 8 fill e1
    v.push_back(mk(0,1,3, 0,3,0, 32'h30,0,1, 3, 0,0,0, 0, 0,0,0,0,0, 3,0));                       // 9 fill e2
    v.push_back(mk(0,1,4, 0,4,0, 32'h40,0,1, 4, 0,0,0, 0, 0,0,0,0,0, 4,1));                       // 10 fill e3 -> full
    v.push_back(mk(0,1,5, 1,0,1, 2,0,1, 5,  0,0,0, 0,  0,0,0,0,0, 4,1));                          // 11 dropped
    v.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,  1,3,32'h300, 0, 1,3,32'h300,32'h30,3, 4,1));          // 12 wake e2
    v.push_back(mk(0,1,9, 1,0,1, 2,0,1, 9,  1,4,32'h400, 1, 1,4,32'h400,32'h40,4, 3,0));          // 13 grant e2, e3 wakes+shifts, dispatch dropped
    v.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,  0,0,0, 1,  0,0,0,0,0, 2,0));                          // 14 grant shifted e3
    v.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,  1,2,32'h200, 0, 1,2,32'h200,32'h20,2, 2,0));          // 15 wake younger B
    v.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,  1,1,32'h100, 0, 1,1,32'h100,32'h10,1, 2,0));          // 16 wake older A
    v.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,  0,0,0, 1,  1,2,32'h200,32'h20,2, 1,0));               // 17 grant A -> B
    v.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,  0,0,0, 1,  0,0,0,0,0, 0,0));                          // 18 grant B
    v.push_back(mk(0,1,6, 32'h66,0,1, 0,20,0, 7, 1,20,32'h1234, 0, 1,6,32'h66,32'h1234,7, 1,0));  // 19 dispatch-time capture
    v.push_back(mk(0,1,7, 1,0,1, 2,0,1, 8,  0,0,0, 0,  1,6,32'h66,32'h1234,7, 2,0));              // 20
    v.push_back(mk(0,1,8, 0,30,0, 3,0,1, 11, 0,0,0, 0, 1,6,32'h66,32'h1234,7, 3,0));              // 21
    v.push_back(mk(1,1,9, 1,0,1, 2,0,1, 12, 1,30,32'h5, 1, 0,0,0,0,0, 0,0));                      // 22 reset wins

    @(negedge clk);
    for (int i = 0; i < v.size(); i++) begin
      reset = v[i].rst; dispatch_en = v[i].den; dispatch_opcode = v[i].dop;
      dispatch_rsdata = v[i].drs; dispatch_rstag = v[i].drstag; dispatch_rsvalid = v[i].drsv;
      dispatch_rtdata = v[i].drt; dispatch_rttag = v[i].drttag; dispatch_rtvalid = v[i].drtv;
      dispatch_rdtag = v[i].drd; cdb_valid = v[i].cv; cdb_tagout = v[i].ct; cdb_out = v[i].cd;
      issue_int = v[i].iss;
      @(posedge clk);
      #1;
      idle_inputs();
      check_outputs($sformatf("vec%0d", i), v[i]);
    end

    // Hand sequence: pending entry woken two cycles after dispatch; wait for
    // ready_int within a bounded number of cycles.
    dispatch_en = 1; dispatch_opcode = 4'hA; dispatch_rstag = 6'd40;
    dispatch_rtdata = 32'h77; dispatch_rtvalid = 1; dispatch_rdtag = 6'd41;
    @(posedge clk); #1; idle_inputs();
    check("seq.pending_not_ready", {31'd0, ready_int}, 32'd0);
    @(posedge clk); #1;
    cdb_valid = 1; cdb_tagout = 6'd40; cdb_out = 32'hCAFE;
    @(posedge clk); #1; idle_inputs();
    begin
      int waited = 0;
      while (!ready_int && waited < 5) begin
        @(posedge clk); #1;
        waited++;
      end
      check("seq.wake_latency", waited, 0);
    end
    check("seq.rsdata", rsdata, 32'hCAFE);
    check("seq.rtdata", rtdata, 32'h77);
    check("seq.rdtag", {26'd0, rdtag}, 32'd41);
    issue_int = 1;
    @(posedge clk); #1; idle_inputs();
    check("seq.count_after_grant", {29'd0, issuequeue_count}, 32'd0);
    check("seq.ready_after_grant", {31'd0, ready_int}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
